// File: rtl/swu_window_maxpool.sv
// Sliding-window max pooling stage.
// Consumes window words (kh outer, kw middle, channel fold inner) and emits one
// pooled word per channel fold when the last tap of that fold arrives.
// Running per-lane maxima live in a small accumulator memory indexed by fold.

module swu_window_maxpool #(
  parameter int SIMD          = 1,
  parameter int IFMChannels   = 2,
  parameter int KERNEL_HEIGHT = 3,
  parameter int KERNEL_WIDTH  = 3,
  parameter int OFMWidth      = 3,
  parameter int OFMHeight     = 5,
  parameter int IP_PRECISION  = 8,
  parameter int SIGNED        = 0,
  parameter     RAM_STYLE     = "auto"
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SIMD*IP_PRECISION-1:0] ip_axis_tdata,
  input  logic                         ip_axis_tvalid,
  output logic                         ip_axis_tready,
  output logic [SIMD*IP_PRECISION-1:0] op_axis_tdata,
  output logic                         op_axis_tvalid,
  input  logic                         op_axis_tready,
  output logic                         frame_done
);

  localparam int W            = SIMD * IP_PRECISION;
  localparam int EFF_CHANNELS = IFMChannels / SIMD;
  localparam int NTAPS        = KERNEL_HEIGHT * KERNEL_WIDTH;
  localparam int NPIX         = OFMWidth * OFMHeight;

  localparam int CW = (EFF_CHANNELS > 1) ? $clog2(EFF_CHANNELS) : 1;
  localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

  // A single-fold design still gets a 1-bit fold index, so keep the memory
  // deep enough that the index never addresses outside it.
  localparam int ACC_DEPTH = (EFF_CHANNELS > 1) ? EFF_CHANNELS : 2;

  localparam logic [CW-1:0] C_LAST = CW'(EFF_CHANNELS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NTAPS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NPIX - 1);

  logic [CW-1:0] c;
  logic [TW-1:0] t;
  logic [PW-1:0] p;

  (* ram_style = RAM_STYLE *) logic [W-1:0] acc [ACC_DEPTH];

  logic [W-1:0] acc_rd;
  logic [W-1:0] pooled;
  logic         first_tap;
  logic         last_tap;
  logic         in_hs;

  // Lane-wise maximum; lanes never interact and ties return the common value.
  function automatic logic [W-1:0] lane_max(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [IP_PRECISION-1:0] la;
    logic [IP_PRECISION-1:0] lb;
    logic                    take;
    lane_max = '0;
    for (int i = 0; i < SIMD; i++) begin
      la = a[i*IP_PRECISION +: IP_PRECISION];
      lb = b[i*IP_PRECISION +: IP_PRECISION];
      if (SIGNED != 0) take = $signed(lb) > $signed(la);
      else             take = lb > la;
      lane_max[i*IP_PRECISION +: IP_PRECISION] = take ? lb : la;
    end
  endfunction

  assign first_tap = (t == '0);
  assign last_tap  = (t == T_LAST);
  assign acc_rd    = acc[c];

  // The first tap seeds the running max, so a stale accumulator is never used.
  assign pooled = first_tap ? ip_axis_tdata : lane_max(acc_rd, ip_axis_tdata);

  // Only the last tap needs room in the output register; all other taps
  // land in the accumulator and can always be taken.
  assign ip_axis_tready = !last_tap || !op_axis_tvalid || op_axis_tready;
  assign in_hs          = ip_axis_tvalid && ip_axis_tready;

  // Accumulator update for every non-final tap (deliberately not reset).
  always_ff @(posedge clk) begin
    if (in_hs && !last_tap) acc[c] <= pooled;
  end

  // Fold, tap and pixel counters advance on each accepted input word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c <= '0;
      t <= '0;
      p <= '0;
    end else if (in_hs) begin
      if (c == C_LAST) begin
        c <= '0;
        if (last_tap) begin
          t <= '0;
          if (p == P_LAST) p <= '0;
          else             p <= p + 1'b1;
        end else begin
          t <= t + 1'b1;
        end
      end else begin
        c <= c + 1'b1;
      end
    end
  end

  // Output register: load on a last-tap word, hold while stalled, clear once taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_axis_tdata  <= '0;
      op_axis_tvalid <= 1'b0;
    end else if (in_hs && last_tap) begin
      op_axis_tdata  <= pooled;
      op_axis_tvalid <= 1'b1;
    end else if (op_axis_tready) begin
      op_axis_tvalid <= 1'b0;
    end
  end

  // One-cycle pulse after the final word of the final pixel in a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= in_hs && (c == C_LAST) && last_tap && (p == P_LAST);
  end

endmodule
